pcpi_initiator: RTL and testbench
=================================

// Module: pcpi_initiator
// PURPOSE
//  Initiator (CPU) end of the PCPI co-processor interface. Accepts one
//  instruction request on a valid/ready command port and drives
//  pcpi_valid/insn/rs1/rs2 to a PCPI responder. Collects pcpi_rd/pcpi_wr on
//  pcpi_ready, or flags a timeout, and returns a response on a valid/ready port.
//  Used as the test driver in front of PCPI_IF responders in the nextpnr models.
// PARAMETERS
//  TIMEOUT   16    cycles with pcpi_valid=1, pcpi_wait=0, no ready -> TIMEOUT (>=1)
//  WAIT_MAX  1024  total cycles in WAIT before HANG; 0 = unbounded
// PORTS
//  clock        in   1   single clock, rising edge
//  resetn       in   1   asynchronous, active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   request accepted when req_valid & req_ready
//  req_insn     in   32  instruction word
//  req_rs1      in   32  operand 1
//  req_rs2      in   32  operand 2
//  rsp_valid    out  1   response present
//  rsp_ready    in   1   response consumed when rsp_valid & rsp_ready
//  rsp_rd       out  32  captured pcpi_rd (0 unless status OK)
//  rsp_wr       out  1   captured pcpi_wr (0 unless status OK)
//  rsp_status   out  2   00 OK, 01 TIMEOUT, 10 HANG, 11 reserved
//  pcpi_valid   out  1   request to responder
//  pcpi_insn    out  32  registered copy of req_insn
//  pcpi_rs1     out  32  registered copy of req_rs1
//  pcpi_rs2     out  32  registered copy of req_rs2
//  pcpi_wr      in   1   responder writes rd
//  pcpi_rd      in   32  responder result
//  pcpi_wait    in   1   responder busy; suspends TIMEOUT
//  pcpi_ready   in   1   responder done (single-cycle pulse expected)
// BEHAVIOUR
//  Reset (resetn=0, async): state IDLE, all outputs 0 except req_ready=1,
//   counters 0. Reset mid-transaction aborts: pcpi_valid drops immediately,
//   no response is produced.
//  FSM states: IDLE, WAIT, RESP.
//   IDLE: req_ready=1. On accept, register insn/rs1/rs2 -> WAIT. pcpi_valid=1
//    from the next cycle (1-cycle issue latency).
//   WAIT: pcpi_valid=1; pcpi_insn/rs1/rs2 held stable. Each cycle:
//    - pcpi_ready=1: capture rd, wr, status=OK -> RESP. Ready takes priority
//      over a TIMEOUT/HANG expiring in the same cycle.
//    - else if pcpi_wait=1: tcnt<=0; wcnt++.
//    - else: tcnt++, wcnt++.
//    - Expiry when tcnt==TIMEOUT-1 and no wait -> status TIMEOUT (TIMEOUT
//      ready-less, wait-free cycles in total).
//    - Expiry when WAIT_MAX!=0 and wcnt==WAIT_MAX-1 -> status HANG.
//    - On either expiry: rd=0, wr=0 -> RESP.
//    - tcnt/wcnt are wide enough for the parameter; they saturate, never wrap.
//   RESP: pcpi_valid=0; rsp_valid=1; rsp_* stable until rsp_ready=1, then
//    -> IDLE. req_ready=0 in WAIT and RESP, so there is one outstanding
//    request and no new request is accepted in the handshake cycle.
//  pcpi_wr/pcpi_rd are ignored outside the ready cycle.
//  pcpi_ready in IDLE or RESP is ignored (spurious).
//  Throughput: at most one request per 3 cycles (accept, ready, rsp handshake).
// TESTING
//  1 req insn=0x0000_000B rs1=5 rs2=3; responder ready+wr, rd=6 on 2nd valid cycle
//    -> rsp_valid 3 cycles after accept, rd=6, wr=1, status=00.
//  2 responder never ready, wait=0 -> pcpi_valid high exactly 16 cycles,
//    then rsp status=01, rd=0, wr=0.
//  3 wait=1 for 100 cycles then ready, rd=0xDEAD_BEEF -> status=00, no timeout;
//    WAIT_MAX=50 with same stimulus -> status=10 after 50 cycles.
//  4 ready asserted on the 16th wait-free cycle -> status=00 (ready wins).
//  5 rsp_ready held 0 for 10 cycles -> rsp_* stable, req_ready=0, a second
//    req_valid stays pending, then is accepted the cycle after the handshake.
//  6 resetn pulled low mid-WAIT -> pcpi_valid=0 asynchronously, no rsp_valid,
//    req_ready=1 after release.

Source files
------------

// File: rtl/pcpi_initiator.sv
// Initiator end of the PCPI co-processor interface: one outstanding request,
// forwarded to a responder, answered as OK, TIMEOUT or HANG.
module pcpi_initiator #(
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned WAIT_MAX = 1024
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_insn,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rd,
  output logic        rsp_wr,
  output logic [1:0]  rsp_status,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_HANG    = 2'b10;

  localparam int unsigned TCW = $clog2(TIMEOUT + 1);
  localparam int unsigned WCW = $clog2(WAIT_MAX + 2);
  localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT - 1);
  localparam logic [WCW-1:0] W_LAST = WCW'(WAIT_MAX - 1);
  localparam bit HANG_EN = (WAIT_MAX != 0);

  logic [1:0]     state_q, state_d;
  logic [31:0]    insn_q, insn_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0]    rd_q, rd_d;
  logic           wr_q, wr_d;
  logic [1:0]     status_q, status_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           t_exp, h_exp;

  always_comb begin
    state_d  = state_q;
    insn_d   = insn_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    status_d = status_q;
    tcnt_d   = tcnt_q;
    wcnt_d   = wcnt_q;
    t_exp    = 1'b0;
    h_exp    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_WAIT;
          insn_d  = req_insn;
          rs1_d   = req_rs1;
          rs2_d   = req_rs2;
          tcnt_d  = '0;
          wcnt_d  = '0;
        end
      end
      S_WAIT: begin
        t_exp = !pcpi_wait && (tcnt_q == T_LAST);
        h_exp = HANG_EN && (wcnt_q == W_LAST);
        // A ready in the same cycle as an expiry still counts as success.
        if (pcpi_ready) begin
          rd_d     = pcpi_rd;
          wr_d     = pcpi_wr;
          status_d = ST_OK;
          state_d  = S_RESP;
        end else if (t_exp || h_exp) begin
          rd_d     = '0;
          wr_d     = 1'b0;
          status_d = t_exp ? ST_TIMEOUT : ST_HANG;
          state_d  = S_RESP;
        end else begin
          if (pcpi_wait) begin
            tcnt_d = '0;
          end else if (tcnt_q != '1) begin
            tcnt_d = tcnt_q + TCW'(1);
          end
          if (wcnt_q != '1) begin
            wcnt_d = wcnt_q + WCW'(1);
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      insn_q   <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      wr_q     <= 1'b0;
      status_q <= ST_OK;
      tcnt_q   <= '0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      insn_q   <= insn_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      status_q <= status_d;
      tcnt_q   <= tcnt_d;
      wcnt_q   <= wcnt_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign pcpi_valid = (state_q == S_WAIT);
  assign rsp_valid  = (state_q == S_RESP);
  assign pcpi_insn  = insn_q;
  assign pcpi_rs1   = rs1_q;
  assign pcpi_rs2   = rs2_q;
  assign rsp_rd     = rd_q;
  assign rsp_wr     = wr_q;
  assign rsp_status = status_q;

endmodule

// File: tb/tb_pcpi_initiator.sv
// Directed bench for pcpi_initiator: expected responses are queued when a
// request is issued and compared when the response handshake occurs.
module tb_pcpi_initiator;

  typedef struct packed {
    logic [31:0] rd;
    logic        wr;
    logic [1:0]  st;
  } rsp_t;

  logic        clock = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_wr;
  logic [31:0] req_insn, req_rs1, req_rs2, rsp_rd;
  logic [1:0]  rsp_status;
  logic        pcpi_valid, pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_rd;

  logic        h_req_valid, h_req_ready, h_rsp_valid, h_rsp_ready, h_rsp_wr;
  logic [31:0] h_rsp_rd, h_pcpi_insn, h_pcpi_rs1, h_pcpi_rs2, h_pcpi_rd;
  logic [1:0]  h_rsp_status;
  logic        h_pcpi_valid, h_pcpi_wr, h_pcpi_wait, h_pcpi_ready;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  rsp_t        exp_q[$];

  always #5 clock = ~clock;

  pcpi_initiator dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rd(rsp_rd), .rsp_wr(rsp_wr), .rsp_status(rsp_status),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
  );

  pcpi_initiator #(.TIMEOUT(16), .WAIT_MAX(50)) dut_h (
    .clock(clock), .resetn(resetn),
    .req_valid(h_req_valid), .req_ready(h_req_ready),
    .req_insn(32'h0000_300B), .req_rs1(32'd7), .req_rs2(32'd9),
    .rsp_valid(h_rsp_valid), .rsp_ready(h_rsp_ready),
    .rsp_rd(h_rsp_rd), .rsp_wr(h_rsp_wr), .rsp_status(h_rsp_status),
    .pcpi_valid(h_pcpi_valid), .pcpi_insn(h_pcpi_insn),
    .pcpi_rs1(h_pcpi_rs1), .pcpi_rs2(h_pcpi_rs2),
    .pcpi_wr(h_pcpi_wr), .pcpi_rd(h_pcpi_rd),
    .pcpi_wait(h_pcpi_wait), .pcpi_ready(h_pcpi_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Returns on the negedge of the first cycle with pcpi_valid expected high.
  task automatic issue(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    int unsigned n = 0;
    req_valid = 1'b1;
    req_insn  = insn;
    req_rs1   = rs1;
    req_rs2   = rs2;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    check("issue_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag);
    int unsigned n = 0;
    rsp_t e;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    check({tag, "_rd"}, rsp_rd, e.rd);
    check({tag, "_wr"}, 32'(rsp_wr), 32'(e.wr));
    check({tag, "_status"}, 32'(rsp_status), 32'(e.st));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cnt;
    resetn = 1'b0;
    req_valid = 1'b0; req_insn = '0; req_rs1 = '0; req_rs2 = '0; rsp_ready = 1'b0;
    pcpi_wr = 1'b0; pcpi_rd = '0; pcpi_wait = 1'b0; pcpi_ready = 1'b0;
    h_req_valid = 1'b0; h_rsp_ready = 1'b0;
    h_pcpi_wr = 1'b0; h_pcpi_rd = '0; h_pcpi_wait = 1'b0; h_pcpi_ready = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_pcpi_valid", 32'(pcpi_valid), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_pcpi_insn", pcpi_insn, 32'd0);
    check("rst_rsp_rd", rsp_rd, 32'd0);
    check("rst_rsp_status", 32'(rsp_status), 32'd0);
    resetn = 1'b1;
    tick();

    // 1: ready on second valid cycle, response three cycles after accept
    exp_q.push_back(rsp_t'{32'd6, 1'b1, 2'b00});
    issue(32'h0000_000B, 32'd5, 32'd3);
    check("t1_valid1", 32'(pcpi_valid), 32'd1);
    check("t1_insn", pcpi_insn, 32'h0000_000B);
    check("t1_rs1", pcpi_rs1, 32'd5);
    check("t1_rs2", pcpi_rs2, 32'd3);
    check("t1_req_ready", 32'(req_ready), 32'd0);
    tick();
    check("t1_valid2", 32'(pcpi_valid), 32'd1);
    check("t1_no_rsp_yet", 32'(rsp_valid), 32'd0);
    pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'd6;
    tick();
    pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = '0;
    check("t1_rsp_latency", 32'(rsp_valid), 32'd1);
    check("t1_valid_drop", 32'(pcpi_valid), 32'd0);
    expect_rsp("t1");
    check("t1_idle", 32'(req_ready), 32'd1);

    // 2: no ready, no wait -> TIMEOUT after 16 valid cycles, rd/wr ignored
    exp_q.push_back(rsp_t'{32'd0, 1'b0, 2'b01});
    issue(32'h0000_002B, 32'd1, 32'd2);
    pcpi_rd = 32'hFFFF_FFFF; pcpi_wr = 1'b1;
    cnt = 0;
    while (pcpi_valid && cnt < 100) begin
      cnt++;
      tick();
    end
    pcpi_rd = '0; pcpi_wr = 1'b0;
    check("t2_valid_cycles", cnt, 32'd16);
    expect_rsp("t2");

    // 2b: one wait cycle restarts the timeout count
    exp_q.push_back(rsp_t'{32'd0, 1'b0, 2'b01});
    issue(32'h0000_004B, 32'd0, 32'd0);
    repeat (10) tick();
    pcpi_wait = 1'b1;
    tick();
    pcpi_wait = 1'b0;
    cnt = 0;
    while (pcpi_valid && cnt < 100) begin
      cnt++;
      tick();
    end
    check("t2b_cycles_after_wait", cnt, 32'd16);
    expect_rsp("t2b");

    // 3: 100 wait cycles then ready -> OK
    exp_q.push_back(rsp_t'{32'hDEAD_BEEF, 1'b1, 2'b00});
    issue(32'h0000_006B, 32'd4, 32'd8);
    pcpi_wait = 1'b1;
    repeat (100) tick();
    check("t3_still_valid", 32'(pcpi_valid), 32'd1);
    pcpi_wait = 1'b0; pcpi_ready = 1'b1; pcpi_rd = 32'hDEAD_BEEF; pcpi_wr = 1'b1;
    tick();
    pcpi_ready = 1'b0; pcpi_rd = '0; pcpi_wr = 1'b0;
    expect_rsp("t3");

    // 3b: WAIT_MAX=50, wait held -> HANG after 50 cycles
    h_pcpi_wait = 1'b1; h_pcpi_rd = 32'h0000_1234; h_pcpi_wr = 1'b1;
    h_req_valid = 1'b1;
    check("t3b_req_ready", 32'(h_req_ready), 32'd1);
    tick();
    h_req_valid = 1'b0;
    cnt = 0;
    while (h_pcpi_valid && cnt < 200) begin
      cnt++;
      tick();
    end
    check("t3b_valid_cycles", cnt, 32'd50);
    check("t3b_rsp_valid", 32'(h_rsp_valid), 32'd1);
    check("t3b_status", 32'(h_rsp_status), 32'd2);
    check("t3b_rd", h_rsp_rd, 32'd0);
    check("t3b_wr", 32'(h_rsp_wr), 32'd0);
    h_rsp_ready = 1'b1;
    tick();
    h_rsp_ready = 1'b0; h_pcpi_wait = 1'b0;
    check("t3b_idle", 32'(h_req_ready), 32'd1);

    // 4: ready on the 16th wait-free cycle wins over the timeout
    exp_q.push_back(rsp_t'{32'h0000_0055, 1'b1, 2'b00});
    issue(32'h0000_008B, 32'd3, 32'd3);
    repeat (15) tick();
    check("t4_valid16", 32'(pcpi_valid), 32'd1);
    pcpi_ready = 1'b1; pcpi_rd = 32'h0000_0055; pcpi_wr = 1'b1;
    tick();
    pcpi_ready = 1'b0; pcpi_rd = '0; pcpi_wr = 1'b0;
    expect_rsp("t4");

    // 5: spurious ready in IDLE, then response back-pressure with a pending request
    pcpi_ready = 1'b1; pcpi_rd = 32'd99;
    tick();
    pcpi_ready = 1'b0; pcpi_rd = '0;
    check("t5_spurious_rsp", 32'(rsp_valid), 32'd0);
    check("t5_spurious_idle", 32'(req_ready), 32'd1);
    exp_q.push_back(rsp_t'{32'h0000_0077, 1'b0, 2'b00});
    exp_q.push_back(rsp_t'{32'h0000_0088, 1'b1, 2'b00});
    issue(32'h0000_00AB, 32'd1, 32'd1);
    pcpi_ready = 1'b1; pcpi_rd = 32'h0000_0077; pcpi_wr = 1'b0;
    tick();
    pcpi_ready = 1'b0;
    req_valid = 1'b1; req_insn = 32'h0000_100B; req_rs1 = 32'd11; req_rs2 = 32'd22;
    for (int i = 0; i < 10; i++) begin
      check("t5_hold_valid", 32'(rsp_valid), 32'd1);
      check("t5_hold_rd", rsp_rd, 32'h0000_0077);
      check("t5_hold_req_ready", 32'(req_ready), 32'd0);
      pcpi_rd = $urandom;
      pcpi_ready = (i == 4);
      tick();
    end
    pcpi_ready = 1'b0; pcpi_rd = '0;
    expect_rsp("t5a");
    check("t5_accept_ready", 32'(req_ready), 32'd1);
    check("t5_accept_novalid", 32'(pcpi_valid), 32'd0);
    tick();
    req_valid = 1'b0;
    check("t5b_valid", 32'(pcpi_valid), 32'd1);
    check("t5b_insn", pcpi_insn, 32'h0000_100B);
    check("t5b_rs2", pcpi_rs2, 32'd22);
    pcpi_ready = 1'b1; pcpi_rd = 32'h0000_0088; pcpi_wr = 1'b1;
    tick();
    pcpi_ready = 1'b0; pcpi_rd = '0; pcpi_wr = 1'b0;
    expect_rsp("t5b");

    // 6: asynchronous reset mid-WAIT aborts the transaction
    issue(32'h0000_200B, 32'd6, 32'd6);
    repeat (3) tick();
    check("t6_pre_valid", 32'(pcpi_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("t6_async_valid", 32'(pcpi_valid), 32'd0);
    check("t6_async_req_ready", 32'(req_ready), 32'd1);
    check("t6_async_rsp", 32'(rsp_valid), 32'd0);
    check("t6_async_insn", pcpi_insn, 32'd0);
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    check("t6_rel_req_ready", 32'(req_ready), 32'd1);
    repeat (5) tick();
    check("t6_no_rsp", 32'(rsp_valid), 32'd0);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
